// File: rtl/div_sequencer_if.sv
// Execute-stage divide handshake: EX operands and control in, stall and results out.
interface div_sequencer_if #(
  parameter int WIDTH = 19
);
  logic             ValidE;
  logic [2:0]       ALUControlE;
  logic             FlushE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             StallDiv;
  logic             DivDone;
  logic [WIDTH-1:0] QuotE;
  logic [WIDTH-1:0] RemE;
  logic             DivByZero;

  modport master (
    output ValidE, ALUControlE, FlushE, SrcAE, SrcBE,
    input  StallDiv, DivDone, QuotE, RemE, DivByZero
  );

  modport slave (
    input  ValidE, ALUControlE, FlushE, SrcAE, SrcBE,
    output StallDiv, DivDone, QuotE, RemE, DivByZero
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the EX stage; stalls the front of the pipe
// while iterating one quotient bit per cycle.
//
// state | meaning
// IDLE  | waiting for a live, unflushed divide in EX
// BUSY  | shift-subtract iterations, pipeline frozen
// DONE  | results valid, DivDone pulses, pipeline advances
module div_sequencer #(
  parameter int         WIDTH  = 19,
  parameter logic [2:0] DIV_OP = 3'b011,
  parameter int         CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  div_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotOut;
  logic [WIDTH-1:0] remOut;
  logic             dbzOut;

  logic             start;
  logic             divZero;
  logic             lastIter;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic             remGe;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH-1:0] quoStep;

  always_comb begin
    stateNext = state;
    start     = bus.ValidE && (bus.ALUControlE == DIV_OP) && !bus.FlushE && (state == IDLE);
    divZero   = (bus.SrcBE == '0);
    lastIter  = (cnt == CNT_W'(WIDTH - 1));
    // Partial remainder is one bit wider than the divisor after the shift.
    remShift  = {remReg, quoReg[WIDTH-1]};
    remGe     = (remShift >= {1'b0, divReg});
    remDiff   = remShift - {1'b0, divReg};
    remStep   = remGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    quoStep   = {quoReg[WIDTH-2:0], remGe};

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = divZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.FlushE) begin
          stateNext = IDLE;
        end else if (lastIter) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      remReg  <= '0;
      quoReg  <= '0;
      divReg  <= '0;
      quotOut <= '0;
      remOut  <= '0;
      dbzOut  <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            if (divZero) begin
              quotOut <= '1;
              remOut  <= bus.SrcAE;
              dbzOut  <= 1'b1;
            end else begin
              remReg <= '0;
              quoReg <= bus.SrcAE;
              divReg <= bus.SrcBE;
              cnt    <= '0;
            end
          end
        end
        BUSY: begin
          // A flush abandons the iteration and leaves the published results alone.
          if (!bus.FlushE) begin
            remReg <= remStep;
            quoReg <= quoStep;
            cnt    <= cnt + CNT_W'(1);
            if (lastIter) begin
              quotOut <= quoStep;
              remOut  <= remStep;
              dbzOut  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.StallDiv  = start || ((state == BUSY) && !bus.FlushE);
  assign bus.DivDone   = (state == DONE);
  assign bus.QuotE     = quotOut;
  assign bus.RemE      = remOut;
  assign bus.DivByZero = dbzOut;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed cases plus random divides
// checked against plain / and % arithmetic.
module tb_div_sequencer;
  localparam int         WIDTH  = 19;
  localparam logic [2:0] DIV_OP = 3'b011;

  typedef struct packed {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
  } resultT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH), .DIV_OP(DIV_OP), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  resultT           expQ[$];
  int               checks   = 0;
  int               failures = 0;
  int               cycleCnt = 0;
  int               startCycle = 0;
  logic [WIDTH-1:0] lastQuo = '0;
  logic [WIDTH-1:0] lastRem = '0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic resultT model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    resultT r;
    if (b == 0) begin
      r.quo = '1;
      r.rem = a;
      r.dbz = 1'b1;
    end else begin
      r.quo = WIDTH'(int'(a) / int'(b));
      r.rem = WIDTH'(int'(a) % int'(b));
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  // Monitor: every DivDone pulse consumes one expected result.
  always @(negedge clk) begin
    resultT e;
    if (reset === 1'b0 && bus.DivDone === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = expQ.pop_front();
        check("quot", 32'(bus.QuotE), 32'(e.quo));
        check("rem", 32'(bus.RemE), 32'(e.rem));
        check("div_by_zero", 32'(bus.DivByZero), 32'(e.dbz));
        check("stall_in_done", 32'(bus.StallDiv), 32'd0);
      end
    end
  end

  // Called just after a rising edge. abortKind: 0 none, 1 flush, 2 reset, applied
  // abortAt cycles after the start cycle (cycle 0).
  task automatic runDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int abortKind, input int abortAt);
    int stalls = 0;
    bit seen = 0;
    bit aborted = 0;
    resultT r;
    bus.ValidE      = 1'b1;
    bus.ALUControlE = DIV_OP;
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    bus.FlushE      = 1'b0;
    startCycle      = cycleCnt;
    if (abortKind == 0) begin
      r = model(a, b);
      expQ.push_back(r);
      lastQuo = r.quo;
      lastRem = r.rem;
    end
    for (int i = 0; i < 80; i++) begin
      if (abortKind == 1 && i == abortAt) bus.FlushE = 1'b1;
      if (abortKind == 2 && i == abortAt) reset = 1'b1;
      @(negedge clk);
      if (abortKind == 1 && i == abortAt) begin
        check("flush_stall_drop", 32'(bus.StallDiv), 32'd0);
        aborted = 1;
      end else if (abortKind == 2 && i == abortAt) begin
        aborted = 1;
      end else if (bus.DivDone === 1'b1) begin
        seen = 1;
      end else if (bus.StallDiv === 1'b1) begin
        stalls++;
      end
      @(posedge clk); #1;
      if (seen || aborted) break;
    end
    bus.ValidE = 1'b0;
    bus.FlushE = 1'b0;
    reset      = 1'b0;
    if (abortKind == 0) begin
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL done_timeout actual=0 expected=1 a=%0d b=%0d", a, b);
      end else begin
        check("stall_cycles", 32'(stalls), (b == 0) ? 32'd1 : 32'(WIDTH + 1));
      end
    end
  endtask

  task automatic idleCycles(input int n, input logic valid, input logic [2:0] op, input logic flush);
    for (int i = 0; i < n; i++) begin
      bus.ValidE      = valid;
      bus.ALUControlE = op;
      bus.FlushE      = flush;
      bus.SrcAE       = WIDTH'($urandom);
      bus.SrcBE       = WIDTH'($urandom);
      @(negedge clk);
      check("idle_stall", 32'(bus.StallDiv), 32'd0);
      check("idle_done", 32'(bus.DivDone), 32'd0);
      @(posedge clk); #1;
    end
    bus.ValidE = 1'b0;
    bus.FlushE = 1'b0;
  endtask

  task automatic checkOutputs(input string tag, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                              input logic dbz);
    @(negedge clk);
    check({tag, "_quot"}, 32'(bus.QuotE), 32'(q));
    check({tag, "_rem"}, 32'(bus.RemE), 32'(r));
    check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(dbz));
    check({tag, "_done"}, 32'(bus.DivDone), 32'd0);
    check({tag, "_stall"}, 32'(bus.StallDiv), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int sel;
    reset           = 1'b1;
    bus.ValidE      = 1'b0;
    bus.ALUControlE = 3'b000;
    bus.FlushE      = 1'b0;
    bus.SrcAE       = '0;
    bus.SrcBE       = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutputs("reset", '0, '0, 1'b0);

    runDiv(19'd20, 19'd10, 0, 0);
    runDiv(19'd524287, 19'd3, 0, 0);
    runDiv(19'd7, 19'd9, 0, 0);
    runDiv(19'd100, 19'd0, 0, 0);
    idleCycles(2, 1'b0, DIV_OP, 1'b0);

    runDiv(19'd50, 19'd5, 1, 5);
    idleCycles(25, 1'b0, 3'b000, 1'b0);
    checkOutputs("flush_hold", lastQuo, lastRem, 1'b1);

    runDiv(19'd1000, 19'd7, 2, 6);
    checkOutputs("mid_reset", '0, '0, 1'b0);
    runDiv(19'd9, 19'd2, 0, 0);

    idleCycles(10, 1'b1, 3'b000, 1'b0);
    idleCycles(3, 1'b1, DIV_OP, 1'b1);

    runDiv(19'd30, 19'd4, 0, 0);
    s1 = startCycle;
    runDiv(19'd31, 19'd4, 0, 0);
    check("b2b_spacing", 32'(startCycle - s1), 32'(WIDTH + 2));

    for (int n = 0; n < 30; n++) begin
      a   = WIDTH'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel < 4)  b = WIDTH'($urandom_range(1, 15));
      else               b = WIDTH'($urandom);
      runDiv(a, b, 0, 0);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3), 1'b1, 3'($urandom_range(4, 7)), 1'b0);
    end

    idleCycles(3, 1'b0, 3'b000, 1'b0);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
